// File: rtl/spi_amp_adc_ctrl.sv
// SPI master for the preamplifier gain word and the multi-channel ADC conversion frames.
// Optional ADC_CLIP_DETECT_EN: flags full-scale samples on the clip output.
module spi_amp_adc_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int AMP_BITS = 8,
    parameter int ADC_BITS = 14,
    parameter int N_CH     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AMP_BITS-1:0]      gain,
    input  logic                     gain_wr,
    input  logic                     start,
    input  logic                     continuous,
    input  logic                     stop,
    input  logic                     miso,
    output logic                     spi_sck,
    output logic                     mosi,
    output logic                     amp_cs_n,
    output logic                     ad_conv,
    output logic                     busy,
    output logic                     amp_done,
    output logic                     sample_valid,
    output logic [N_CH*ADC_BITS-1:0] samples,
    output logic [N_CH-1:0]          clip
);
    localparam int FRAME = N_CH*(ADC_BITS+2)+2;
    localparam int CW    = $clog2(2*CLK_DIV);
    localparam int MAXB  = (FRAME > AMP_BITS) ? FRAME : AMP_BITS;
    localparam int BW    = $clog2(MAXB);

    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV-1);
    localparam logic [CW-1:0] PER_LAST   = CW'(2*CLK_DIV-1);
    localparam logic [BW-1:0] AMP_LAST   = BW'(AMP_BITS-1);
    localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME-1);

`ifdef ADC_CLIP_DETECT_EN
    localparam logic [ADC_BITS-1:0] CODE_MAX = {1'b0, {(ADC_BITS-1){1'b1}}};
    localparam logic [ADC_BITS-1:0] CODE_MIN = {1'b1, {(ADC_BITS-1){1'b0}}};
`endif

    typedef enum logic [2:0] {IDLE, AMP_SHIFT, AMP_GAP, CONV, ADC_SHIFT, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [BW-1:0]       bit_cnt;
    logic [AMP_BITS-1:0] amp_sr;
    logic [FRAME-3:0]    adc_sr;
    logic                gain_pending;
    logic                start_pending;
    logic                cont_mode;

    // The first two lead bits fall off the top of adc_sr, so data offsets count from FRAME-3.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            amp_sr        <= '0;
            adc_sr        <= '0;
            gain_pending  <= 1'b0;
            start_pending <= 1'b0;
            cont_mode     <= 1'b0;
            spi_sck       <= 1'b0;
            mosi          <= 1'b0;
            amp_cs_n      <= 1'b1;
            ad_conv       <= 1'b0;
            busy          <= 1'b0;
            amp_done      <= 1'b0;
            sample_valid  <= 1'b0;
            samples       <= '0;
`ifdef ADC_CLIP_DETECT_EN
            clip          <= '0;
`endif
        end else begin
            amp_done     <= 1'b0;
            sample_valid <= 1'b0;
            if (stop && state != IDLE)
                cont_mode <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    spi_sck <= 1'b0;
                    if (gain_wr || gain_pending) begin
                        gain_pending  <= 1'b1;
                        start_pending <= start;
                        if (start)
                            cont_mode <= continuous;
                        if (gain_wr) begin
                            amp_sr <= gain;
                            mosi   <= gain[AMP_BITS-1];
                        end else begin
                            mosi   <= amp_sr[AMP_BITS-1];
                        end
                        amp_cs_n <= 1'b0;
                        busy     <= 1'b1;
                        state    <= AMP_SHIFT;
                    end else if (start) begin
                        cont_mode <= continuous;
                        ad_conv   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                AMP_SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt == AMP_LAST) begin
                                bit_cnt  <= '0;
                                mosi     <= 1'b0;
                                amp_cs_n <= 1'b1;
                                state    <= AMP_GAP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                amp_sr  <= amp_sr << 1;
                                mosi    <= amp_sr[AMP_BITS-2];
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                AMP_GAP: begin
                    if (cnt == PER_LAST) begin
                        cnt          <= '0;
                        amp_done     <= 1'b1;
                        gain_pending <= 1'b0;
                        if (start_pending) begin
                            start_pending <= 1'b0;
                            ad_conv       <= 1'b1;
                            state         <= CONV;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CONV: begin
                    if (cnt == PER_LAST) begin
                        cnt     <= '0;
                        ad_conv <= 1'b0;
                        state   <= ADC_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ADC_SHIFT: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                            adc_sr  <= {adc_sr[FRAME-4:0], miso};
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt == FRAME_LAST) begin
                                bit_cnt      <= '0;
                                sample_valid <= 1'b1;
                                for (int c = 0; c < N_CH; c++) begin
                                    samples[c*ADC_BITS +: ADC_BITS] <=
                                        adc_sr[FRAME-3-c*(ADC_BITS+2) -: ADC_BITS];
`ifdef ADC_CLIP_DETECT_EN
                                    clip[c] <=
                                        (adc_sr[FRAME-3-c*(ADC_BITS+2) -: ADC_BITS] == CODE_MAX) ||
                                        (adc_sr[FRAME-3-c*(ADC_BITS+2) -: ADC_BITS] == CODE_MIN);
`endif
                                end
                                state <= DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // A stop arriving in this very cycle still ends the run.
                    if (cont_mode && !stop) begin
                        ad_conv <= 1'b1;
                        state   <= CONV;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef ADC_CLIP_DETECT_EN
    assign clip = '0;
`endif

endmodule

// File: tb/tb_spi_amp_adc_ctrl.sv
// Self-checking bench for spi_amp_adc_ctrl: ADC slave model on miso plus a sample scoreboard.
`timescale 1ns/1ps
module tb_spi_amp_adc_ctrl;
    localparam int CLK_DIV  = 2;
    localparam int AMP_BITS = 8;
    localparam int ADC_BITS = 14;
    localparam int N_CH     = 2;
    localparam int FRAME    = N_CH*(ADC_BITS+2)+2;
    localparam int LAT      = 1 + 2*CLK_DIV + FRAME*2*CLK_DIV + 1;
    localparam int PERIOD   = 2*CLK_DIV*(FRAME+1)+1;
    localparam int AMP_T    = AMP_BITS*2*CLK_DIV + 2*CLK_DIV;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [AMP_BITS-1:0]      gain = '0;
    logic                     gain_wr = 1'b0;
    logic                     start = 1'b0;
    logic                     continuous = 1'b0;
    logic                     stop = 1'b0;
    logic                     miso = 1'b0;
    logic                     spi_sck, mosi, amp_cs_n, ad_conv, busy, amp_done, sample_valid;
    logic [N_CH*ADC_BITS-1:0] samples;
    logic [N_CH-1:0]          clip;

    always #5 clk = ~clk;

    spi_amp_adc_ctrl #(
        .CLK_DIV(CLK_DIV), .AMP_BITS(AMP_BITS), .ADC_BITS(ADC_BITS), .N_CH(N_CH)
    ) dut (
        .clk(clk), .rst(rst), .gain(gain), .gain_wr(gain_wr), .start(start),
        .continuous(continuous), .stop(stop), .miso(miso), .spi_sck(spi_sck),
        .mosi(mosi), .amp_cs_n(amp_cs_n), .ad_conv(ad_conv), .busy(busy),
        .amp_done(amp_done), .sample_valid(sample_valid), .samples(samples), .clip(clip)
    );

    typedef struct {
        logic [ADC_BITS-1:0] ch0;
        logic [ADC_BITS-1:0] ch1;
        logic [1:0]          clip_en;
    } vec_t;

    typedef struct {
        logic [N_CH*ADC_BITS-1:0] samples;
        logic [1:0]               clip;
        int                       start_cyc;
        int                       latency;
    } exp_t;

    exp_t                sb[$];
    vec_t                vecs[5];
    int                  checks = 0;
    int                  failures = 0;
    int                  cyc = 0;
    int                  valid_count = 0;
    logic [ADC_BITS-1:0] cur_ch0 = '0;
    logic [ADC_BITS-1:0] cur_ch1 = '0;
    int                  bit_idx = 0;
    logic                sck_prev = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] expClip(input logic [1:0] en);
`ifdef ADC_CLIP_DETECT_EN
        return en;
`else
        return 2'b00 & en;
`endif
    endfunction

    // Frame as the ADC presents it: lead bits deliberately nonzero so a misaligned capture shows.
    function automatic logic frameBit(input int i);
        logic [FRAME-1:0] f;
        f = {2'b10, cur_ch0, 2'b01, cur_ch1, 2'b11};
        if (i >= FRAME)
            return 1'b0;
        return f[FRAME-1-i];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ad_conv === 1'b1) begin
            bit_idx = 0;
        end else if (spi_sck === 1'b1 && sck_prev === 1'b0) begin
            bit_idx = bit_idx + 1;
        end
        miso     = frameBit(bit_idx);
        sck_prev = spi_sck;
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sample_valid === 1'b1) begin
            valid_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_sample_valid", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                checkOutput("samples", 64'(samples), 64'(e.samples));
                checkOutput("clip", 64'(clip), 64'(e.clip));
                checkOutput("latency", 64'(cyc - e.start_cyc + 1), 64'(e.latency));
            end
        end
    end

    // Drives one request at the current negedge and pushes the frames it should produce.
    task automatic applyStimulus(input logic gw, input logic [AMP_BITS-1:0] g, input logic st,
                                 input logic cont, input int lat, input int frames,
                                 input logic [1:0] clip_en);
        exp_t e;
        for (int k = 0; k < frames; k++) begin
            e.samples   = {cur_ch1, cur_ch0};
            e.clip      = expClip(clip_en);
            e.start_cyc = cyc;
            e.latency   = lat + k*PERIOD;
            sb.push_back(e);
        end
        gain       = g;
        gain_wr    = gw;
        start      = st;
        continuous = cont;
        @(negedge clk);
        gain_wr    = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
    endtask

    task automatic waitValid(input int limit, output bit seen);
        int i;
        seen = 1'b0;
        i = 0;
        while (!seen && i < limit) begin
            @(negedge clk);
            if (sample_valid === 1'b1)
                seen = 1'b1;
            i++;
        end
    endtask

    task automatic waitIdle(input string name, input int limit);
        int i;
        i = 0;
        while (busy !== 1'b0 && i < limit) begin
            @(negedge clk);
            i++;
        end
        checkOutput(name, 64'(busy), 64'(0));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_sck"}, 64'(spi_sck), 64'(0));
        checkOutput({tag, "_mosi"}, 64'(mosi), 64'(0));
        checkOutput({tag, "_amp_cs_n"}, 64'(amp_cs_n), 64'(1));
        checkOutput({tag, "_ad_conv"}, 64'(ad_conv), 64'(0));
        checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
        checkOutput({tag, "_amp_done"}, 64'(amp_done), 64'(0));
        checkOutput({tag, "_sample_valid"}, 64'(sample_valid), 64'(0));
        checkOutput({tag, "_samples"}, 64'(samples), 64'(0));
        checkOutput({tag, "_clip"}, 64'(clip), 64'(0));
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : test
        bit              seen;
        int              low_cnt, rise_cnt, done_t, done_cnt, mosi_bad, conv_cnt, conv_t, v0;
        logic [7:0]      mosi_bits;
        logic            prev_sck;

        vecs[0] = '{ch0: 14'h0ABC, ch1: 14'h3F01, clip_en: 2'b00};
        vecs[1] = '{ch0: 14'h1FFF, ch1: 14'h0000, clip_en: 2'b01};
        vecs[2] = '{ch0: 14'h2000, ch1: 14'h1FFF, clip_en: 2'b11};
        vecs[3] = '{ch0: 14'h0000, ch1: 14'h2000, clip_en: 2'b10};
        vecs[4] = '{ch0: 14'h1234, ch1: 14'h2ABC, clip_en: 2'b00};

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Amplifier programming with 8'h11
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 0, 0, 2'b00);
        low_cnt = 0; rise_cnt = 0; done_t = -1; done_cnt = 0; mosi_bad = 0;
        mosi_bits = '0; prev_sck = 1'b0;
        for (int t = 0; t < 60; t++) begin
            if (amp_cs_n === 1'b0) low_cnt++;
            else if (mosi !== 1'b0) mosi_bad++;
            if (spi_sck === 1'b1 && prev_sck === 1'b0) begin
                rise_cnt++;
                mosi_bits = {mosi_bits[6:0], mosi};
            end
            prev_sck = spi_sck;
            if (amp_done === 1'b1) begin
                done_cnt++;
                if (done_t < 0) done_t = t;
            end
            @(negedge clk);
        end
        checkOutput("amp_cs_low_cycles", 64'(low_cnt), 64'(32));
        checkOutput("amp_sck_rises", 64'(rise_cnt), 64'(AMP_BITS));
        checkOutput("amp_mosi_bits", 64'(mosi_bits), 64'(8'h11));
        checkOutput("amp_done_time", 64'(done_t), 64'(AMP_T));
        checkOutput("amp_done_pulses", 64'(done_cnt), 64'(1));
        checkOutput("mosi_idle_zero", 64'(mosi_bad), 64'(0));
        checkOutput("amp_busy_after", 64'(busy), 64'(0));

        // Single-shot conversions from the vector table
        for (int i = 0; i < 5; i++) begin
            cur_ch0 = vecs[i].ch0;
            cur_ch1 = vecs[i].ch1;
            applyStimulus(1'b0, '0, 1'b1, 1'b0, LAT, 1, vecs[i].clip_en);
            waitValid(400, seen);
            checkOutput("single_valid_seen", 64'(seen), 64'(1));
            @(negedge clk);
            checkOutput("busy_falls_after_valid", 64'(busy), 64'(0));
            repeat (5) @(negedge clk);
            checkOutput("samples_hold", 64'(samples), 64'({vecs[i].ch1, vecs[i].ch0}));
        end

        // gain_wr and start in the same cycle
        cur_ch0 = 14'h0155;
        cur_ch1 = 14'h2AAA;
        v0 = valid_count;
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0, AMP_T + LAT, 1, 2'b00);
        conv_cnt = 0; conv_t = -1; done_t = -1; done_cnt = 0;
        for (int t = 1; t < 400 && busy === 1'b1; t++) begin
            if (amp_done === 1'b1) begin
                done_cnt++;
                done_t = t;
            end
            if (ad_conv === 1'b1) begin
                conv_cnt++;
                if (conv_t < 0) conv_t = t;
            end
            @(negedge clk);
        end
        checkOutput("combo_amp_done_pulses", 64'(done_cnt), 64'(1));
        checkOutput("combo_conv_cycles", 64'(conv_cnt), 64'(2*CLK_DIV));
        checkOutput("combo_conv_after_amp", 64'(conv_t), 64'(done_t));
        waitIdle("combo_idle", 400);
        repeat (3) @(negedge clk);
        checkOutput("combo_valid_count", 64'(valid_count - v0), 64'(1));

        // Continuous mode, stop during the third frame
        cur_ch0 = 14'h1FFF;
        cur_ch1 = 14'h2000;
        v0 = valid_count;
        applyStimulus(1'b0, '0, 1'b1, 1'b1, LAT, 3, 2'b11);
        waitValid(400, seen);
        checkOutput("cont_valid1_seen", 64'(seen), 64'(1));
        waitValid(400, seen);
        checkOutput("cont_valid2_seen", 64'(seen), 64'(1));
        repeat (50) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        waitIdle("cont_idle", 600);
        repeat (PERIOD) @(negedge clk);
        checkOutput("cont_valid_count", 64'(valid_count - v0), 64'(3));

        // Reset in the middle of ADC_SHIFT
        cur_ch0 = 14'h0777;
        cur_ch1 = 14'h0888;
        v0 = valid_count;
        applyStimulus(1'b0, '0, 1'b1, 1'b0, LAT, 0, 2'b00);
        repeat (58) @(negedge clk);
        checkOutput("abort_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        checkResetValues("abort");
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        checkOutput("abort_no_valid", 64'(valid_count - v0), 64'(0));
        checkOutput("abort_busy_after", 64'(busy), 64'(0));

        checkOutput("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
